// File: rtl/pc_context_mux.sv
// PC/interrupt write-back multiplexer with latched IRQs, fixed-priority offer/ack and a LIFO of saved PCs.
// Optional per-line interrupt mask enabled by defining PC_CONTEXT_IRQ_MASK_EN.
module pc_context_mux #(
    parameter int PC_WIDTH    = 11,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_IRQ     = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [PC_WIDTH-1:0]        valor_pc,
    input  logic [DATA_WIDTH-1:0]      dado,
    input  logic [NUM_IRQ-1:0]         irq_req,
`ifdef PC_CONTEXT_IRQ_MASK_EN
    input  logic [NUM_IRQ-1:0]         irq_mask,
`endif
    input  logic                       irq_enable,
    input  logic                       irq_ack,
    input  logic                       irq_return,
    input  logic                       save_pc,
    input  logic                       save_pc_buffer,
    input  logic                       get_interruption,
    output logic                       irq_valid,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id,
    output logic                       stack_full,
    output logic                       stack_err,
    output logic [DATA_WIDTH-1:0]      escolhido,
    output logic [1:0]                 dbg_state
);

    localparam int IW = $clog2(NUM_IRQ);
    localparam int SW = $clog2(STACK_DEPTH);

    // Handshake: irq_valid/irq_id are offered until irq_ack is seen in the same cycle as irq_valid;
    // the offer is withdrawn only if irq_enable drops or irq_return is processed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_IRQ-1:0]    r_pending;
    logic [PC_WIDTH-1:0]   r_stk_pc [STACK_DEPTH];
    logic [IW-1:0]         r_stk_id [STACK_DEPTH];
    logic [SW:0]           r_sp;
    logic                  r_irq_valid;
    logic [IW-1:0]         r_irq_id;
    logic                  r_stack_err;
    logic [DATA_WIDTH-1:0] r_escolhido;

    logic                  w_empty;
    logic                  w_full;
    logic [SW-1:0]         w_top_idx;
    logic [SW-1:0]         w_under_idx;
    logic [PC_WIDTH-1:0]   w_top_pc;
    logic [IW:0]           w_cur_level;
    logic [IW-1:0]         w_next_top_id;
    logic [NUM_IRQ-1:0]    w_mask;
    logic [NUM_IRQ-1:0]    w_eligible;
    logic [IW-1:0]         w_lowest;
    logic                  w_any_elig;
    logic                  w_ack;
    logic [NUM_IRQ-1:0]    w_clear;

`ifdef PC_CONTEXT_IRQ_MASK_EN
    assign w_mask = irq_mask;
`else
    assign w_mask = '0;
`endif

    assign w_empty     = (r_sp == '0);
    assign w_full      = (r_sp == (SW+1)'(STACK_DEPTH));
    assign w_top_idx   = SW'(r_sp - (SW+1)'(1));
    assign w_under_idx = SW'(r_sp - (SW+1)'(2));
    assign w_top_pc    = w_empty ? '0 : r_stk_pc[w_top_idx];
    assign w_cur_level = w_empty ? (IW+1)'(NUM_IRQ) : {1'b0, r_stk_id[w_top_idx]};
    // Id shown after a pop: the entry below the current top, or 0 once the stack drains.
    assign w_next_top_id = (r_sp >= (SW+1)'(2)) ? r_stk_id[w_under_idx] : '0;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_eligible[i] = r_pending[i] & irq_enable & ~w_mask[i] & ((IW+1)'(i) < w_cur_level);
        end
    end

    always_comb begin
        w_lowest = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) w_lowest = IW'(i);
        end
    end

    assign w_any_elig = |w_eligible;
    assign w_ack      = (r_state == ST_OFFER) & irq_ack & ~irq_return;
    assign w_clear    = w_ack ? (NUM_IRQ'(1) << r_irq_id) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sp        <= '0;
            r_irq_valid <= 1'b0;
            r_irq_id    <= '0;
            r_stack_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stk_pc[i] <= '0;
                r_stk_id[i] <= '0;
            end
        end else if (irq_return) begin
            // A return overrides any same-cycle ack and always lands in IDLE.
            if (w_empty) r_stack_err <= 1'b1;
            else         r_sp        <= r_sp - (SW+1)'(1);
            r_state     <= ST_IDLE;
            r_irq_valid <= 1'b0;
            r_irq_id    <= w_next_top_id;
        end else begin
            case (r_state)
                ST_IDLE, ST_SERVICE: begin
                    if (w_any_elig && !w_full) begin
                        r_state     <= ST_OFFER;
                        r_irq_valid <= 1'b1;
                        r_irq_id    <= w_lowest;
                    end
                end
                ST_OFFER: begin
                    if (irq_ack) begin
                        r_stk_pc[r_sp[SW-1:0]] <= valor_pc;
                        r_stk_id[r_sp[SW-1:0]] <= r_irq_id;
                        r_sp        <= r_sp + (SW+1)'(1);
                        r_irq_valid <= 1'b0;
                        r_state     <= ST_SERVICE;
                    end else if (!irq_enable) begin
                        r_irq_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_irq_valid <= 1'b0;
                end
            endcase
        end
    end

    // New requests win over the clear of the acknowledged line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending   <= '0;
            r_escolhido <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | irq_req;
            if (save_pc)               r_escolhido <= DATA_WIDTH'(valor_pc);
            else if (save_pc_buffer)   r_escolhido <= DATA_WIDTH'(w_top_pc);
            else if (get_interruption) r_escolhido <= DATA_WIDTH'(r_irq_id) + DATA_WIDTH'(1);
            else                       r_escolhido <= dado;
        end
    end

    assign irq_valid  = r_irq_valid;
    assign irq_id     = r_irq_id;
    assign stack_full = w_full;
    assign stack_err  = r_stack_err;
    assign escolhido  = r_escolhido;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_pc_context_mux.sv
// Bench for pc_context_mux: queue-based context model checked every cycle plus directed literal checks.
module tb_pc_context_mux;

    localparam int PCW = 11;
    localparam int DW  = 32;
    localparam int NI  = 4;
    localparam int SD  = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [PCW-1:0] valor_pc = '0;
    logic [DW-1:0]  dado = '0;
    logic [NI-1:0]  irq_req = '0;
    logic [NI-1:0]  irq_mask = '0;
    logic           irq_enable = 1'b0;
    logic           irq_ack = 1'b0;
    logic           irq_return = 1'b0;
    logic           save_pc = 1'b0;
    logic           save_pc_buffer = 1'b0;
    logic           get_interruption = 1'b0;
    logic           irq_valid;
    logic [1:0]     irq_id;
    logic           stack_full;
    logic           stack_err;
    logic [DW-1:0]  escolhido;
    logic [1:0]     dbg_state;

    always #5 clock = ~clock;

    pc_context_mux #(
        .PC_WIDTH(PCW), .DATA_WIDTH(DW), .NUM_IRQ(NI), .STACK_DEPTH(SD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .valor_pc(valor_pc),
        .dado(dado),
        .irq_req(irq_req),
`ifdef PC_CONTEXT_IRQ_MASK_EN
        .irq_mask(irq_mask),
`endif
        .irq_enable(irq_enable),
        .irq_ack(irq_ack),
        .irq_return(irq_return),
        .save_pc(save_pc),
        .save_pc_buffer(save_pc_buffer),
        .get_interruption(get_interruption),
        .irq_valid(irq_valid),
        .irq_id(irq_id),
        .stack_full(stack_full),
        .stack_err(stack_err),
        .escolhido(escolhido),
        .dbg_state(dbg_state)
    );

    typedef struct {
        int id;
        int pc;
    } ctx_t;

    ctx_t          m_stack[$];
    bit            m_pend[NI];
    bit            m_valid = 1'b0;
    int            m_id = 0;
    bit            m_err = 1'b0;
    logic [DW-1:0] m_esc = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_stack.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_id    = 0;
        m_err   = 1'b0;
        m_esc   = '0;
    endfunction

    function automatic void model_step();
        logic [NI-1:0] mk;
        int  level;
        int  lowest;
        bit  ack;
        int  clr_id;
        int  n;
`ifdef PC_CONTEXT_IRQ_MASK_EN
        mk = irq_mask;
`else
        mk = '0;
`endif
        n = m_stack.size();
        if (save_pc)               m_esc = DW'(valor_pc);
        else if (save_pc_buffer)   m_esc = (n > 0) ? DW'(m_stack[n-1].pc) : '0;
        else if (get_interruption) m_esc = DW'(m_id + 1);
        else                       m_esc = dado;

        level  = (n > 0) ? m_stack[n-1].id : NI;
        lowest = -1;
        for (int i = 0; i < NI; i++) begin
            if (lowest < 0 && m_pend[i] && irq_enable && !mk[i] && i < level) lowest = i;
        end

        ack    = m_valid && irq_ack && !irq_return;
        clr_id = m_id;
        if (irq_return) begin
            if (n > 0) void'(m_stack.pop_back());
            else       m_err = 1'b1;
            m_valid = 1'b0;
            m_id    = (m_stack.size() > 0) ? m_stack[m_stack.size()-1].id : 0;
        end else if (m_valid) begin
            if (irq_ack) begin
                m_stack.push_back('{id: m_id, pc: int'(valor_pc)});
                m_valid = 1'b0;
            end else if (!irq_enable) begin
                m_valid = 1'b0;
            end
        end else if (lowest >= 0 && n < SD) begin
            m_valid = 1'b1;
            m_id    = lowest;
        end

        for (int i = 0; i < NI; i++) begin
            m_pend[i] = (m_pend[i] && !(ack && i == clr_id)) || irq_req[i];
        end
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
        #1;
        check("model_valid", DW'(irq_valid), DW'(m_valid));
        check("model_id", DW'(irq_id), DW'(m_id));
        check("model_full", DW'(stack_full), DW'(m_stack.size() == SD));
        check("model_err", DW'(stack_err), DW'(m_err));
        check("model_escolhido", escolhido, m_esc);
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;
        check("rst_valid", DW'(irq_valid), 0);
        check("rst_esc", escolhido, 0);
        check("rst_err", DW'(stack_err), 0);

        // Mux priority
        dado = 32'hDEADBEEF;
        valor_pc = 11'h123;
        save_pc = 1'b1;
        save_pc_buffer = 1'b1;
        cyc();
        check("mux_save_pc", escolhido, 32'h123);
        save_pc = 1'b0;
        save_pc_buffer = 1'b0;
        cyc();
        check("mux_dado", escolhido, 32'hDEADBEEF);

        // Basic IRQ on line 2
        irq_enable = 1'b1;
        irq_req = 4'b0100;
        cyc();
        irq_req = '0;
        cyc();
        check("basic_valid", DW'(irq_valid), 1);
        check("basic_id", DW'(irq_id), 2);
        valor_pc = 11'h040;
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        check("basic_ack_valid", DW'(irq_valid), 0);
        check("basic_full", DW'(stack_full), 0);
        save_pc_buffer = 1'b1;
        cyc();
        save_pc_buffer = 1'b0;
        check("basic_tos", escolhido, 32'h40);
        get_interruption = 1'b1;
        cyc();
        get_interruption = 1'b0;
        check("basic_code", escolhido, 32'h3);

        // Preemption by line 0
        irq_req = 4'b0001;
        cyc();
        irq_req = '0;
        cyc();
        check("pre_valid", DW'(irq_valid), 1);
        check("pre_id", DW'(irq_id), 0);
        valor_pc = 11'h055;
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        irq_return = 1'b1;
        cyc();
        irq_return = 1'b0;
        check("pre_ret_id", DW'(irq_id), 2);
        save_pc_buffer = 1'b1;
        cyc();
        save_pc_buffer = 1'b0;
        check("pre_ret_tos", escolhido, 32'h40);
        irq_return = 1'b1;
        cyc();
        irq_return = 1'b0;
        check("pre_empty_id", DW'(irq_id), 0);

        // Four nested levels fill the stack
        for (int k = 3; k >= 0; k--) begin
            irq_req = NI'(1 << k);
            cyc();
            irq_req = '0;
            cyc();
            check("nest_valid", DW'(irq_valid), 1);
            check("nest_id", DW'(irq_id), DW'(k));
            valor_pc = PCW'(16 * k + 1);
            irq_ack = 1'b1;
            cyc();
            irq_ack = 1'b0;
        end
        check("nest_full", DW'(stack_full), 1);
        cyc(3);
        check("nest_no_offer", DW'(irq_valid), 0);

        // Five returns: the fifth underflows
        for (int i = 0; i < 5; i++) begin
            irq_return = 1'b1;
            cyc();
            check("unwind_err", DW'(stack_err), (i == 4) ? 1 : 0);
            if (i == 0) check("unwind_id", DW'(irq_id), 1);
        end
        irq_return = 1'b0;
        cyc(2);
        check("err_sticky", DW'(stack_err), 1);

        // Request held through its own ack stays pending
        irq_req = 4'b0010;
        cyc(2);
        check("setwin_valid", DW'(irq_valid), 1);
        check("setwin_id", DW'(irq_id), 1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        irq_req = '0;
        irq_return = 1'b1;
        cyc();
        irq_return = 1'b0;
        check("setwin_ret_valid", DW'(irq_valid), 0);
        cyc();
        check("setwin_reoffer", DW'(irq_valid), 1);
        check("setwin_reoffer_id", DW'(irq_id), 1);

        // Ack and return together: return wins, the ack is dropped
        irq_ack = 1'b1;
        irq_return = 1'b1;
        cyc();
        irq_ack = 1'b0;
        irq_return = 1'b0;
        check("ackret_valid", DW'(irq_valid), 0);
        cyc();
        check("ackret_reoffer", DW'(irq_valid), 1);
        check("ackret_id", DW'(irq_id), 1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        irq_return = 1'b1;
        cyc();
        irq_return = 1'b0;

`ifdef PC_CONTEXT_IRQ_MASK_EN
        irq_mask = 4'b0001;
        irq_req = 4'b0011;
        cyc();
        irq_req = '0;
        cyc();
        check("mask_id", DW'(irq_id), 1);
        check("mask_valid", DW'(irq_valid), 1);
        valor_pc = 11'h077;
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        irq_mask = '0;
        cyc();
        check("unmask_valid", DW'(irq_valid), 1);
        check("unmask_id", DW'(irq_id), 0);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        irq_return = 1'b1;
        cyc(2);
        irq_return = 1'b0;
        cyc();
`endif

        // Asynchronous reset in the middle of a service
        dado = 32'h0000_00A5;
        irq_req = 4'b0100;
        cyc();
        irq_req = '0;
        cyc();
        valor_pc = 11'h003;
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        cyc();
        check("pre_rst_esc", escolhido, 32'hA5);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", DW'(irq_valid), 0);
        check("async_id", DW'(irq_id), 0);
        check("async_full", DW'(stack_full), 0);
        check("async_err", DW'(stack_err), 0);
        check("async_esc", escolhido, 0);
        @(negedge clock);
        reset = 1'b0;
        save_pc_buffer = 1'b1;
        cyc();
        save_pc_buffer = 1'b0;
        check("post_rst_tos", escolhido, 0);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
